// File: rtl/fpalu_arb.sv
// fpalu_arb: shares one fixed-latency FPALU between two requesters. Round-robin grant,
// registered issue, a latency-matched tag pipeline that routes each result to its owner,
// and an idle-driven sleep FSM that lets the top gate the ALU clock.
module fpalu_arb #(
  parameter int unsigned ALU_LAT  = 4,
  parameter int unsigned TAGW     = 4,
  parameter int unsigned IDLE_CYC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            rq0_valid,
  output logic            rq0_ready,
  input  logic            rq0_add_muln,
  input  logic [28:0]     rq0_a,
  input  logic [28:0]     rq0_b,
  input  logic [TAGW-1:0] rq0_tag,
  input  logic            rq1_valid,
  output logic            rq1_ready,
  input  logic            rq1_add_muln,
  input  logic [28:0]     rq1_a,
  input  logic [28:0]     rq1_b,
  input  logic [TAGW-1:0] rq1_tag,
  output logic            alu_add_muln,
  output logic [28:0]     alu_a,
  output logic [28:0]     alu_b,
  input  logic [28:0]     alu_y,
  output logic            rsp0_valid,
  output logic            rsp1_valid,
  output logic [28:0]     rsp_y,
  output logic [TAGW-1:0] rsp_tag,
  output logic [2:0]      inflight,
  output logic            alu_sleep
);

  typedef enum logic [1:0] {StActive, StSleep, StWake} state_e;

  state_e           state_q, state_d;
  logic [7:0]       idle_q, idle_d;
  logic             last_grant_q;
  logic             gnt0, gnt1, gnt;
  logic [ALU_LAT:0] pipe_v_q, pipe_p_q;
  logic [TAGW-1:0]  pipe_tag_q [0:ALU_LAT];
  logic             done;
  logic [2:0]       inflight_q, inflight_d;
  logic             alu_add_muln_q;
  logic [28:0]      alu_a_q, alu_b_q;
  logic             rsp0_valid_q, rsp1_valid_q;
  logic [28:0]      rsp_y_q;
  logic [TAGW-1:0]  rsp_tag_q;

  // Round-robin grant: a lone requester wins; on contention the port not granted last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StActive && !flush) begin
      if (rq0_valid && (!rq1_valid || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (rq1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign gnt       = gnt0 | gnt1;
  assign rq0_ready = gnt0;
  assign rq1_ready = gnt1;
  // Oldest pipeline slot valid: alu_y belongs to that op this cycle.
  assign done      = pipe_v_q[ALU_LAT];

  // Grant history; flush leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (gnt) begin
      last_grant_q <= gnt1;
    end
  end

  // Issue register; holds its value between grants to avoid toggling the ALU inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_add_muln_q <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
    end else if (gnt) begin
      alu_add_muln_q <= gnt1 ? rq1_add_muln : rq0_add_muln;
      alu_a_q        <= gnt1 ? rq1_a : rq0_a;
      alu_b_q        <= gnt1 ? rq1_b : rq0_b;
    end
  end

  // Tag pipeline: {valid, port, tag} travels alongside the op through the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q <= '0;
      pipe_p_q <= '0;
      for (int unsigned i = 0; i <= ALU_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      pipe_v_q <= flush ? '0 : {pipe_v_q[ALU_LAT-1:0], gnt};
      pipe_p_q <= {pipe_p_q[ALU_LAT-1:0], gnt1};
      if (gnt) pipe_tag_q[0] <= gnt1 ? rq1_tag : rq0_tag;
      for (int unsigned i = 1; i <= ALU_LAT; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
    end
  end

  // Response register: capture alu_y and pulse the owner's valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_y_q      <= '0;
      rsp_tag_q    <= '0;
    end else begin
      rsp0_valid_q <= !flush && done && !pipe_p_q[ALU_LAT];
      rsp1_valid_q <= !flush && done && pipe_p_q[ALU_LAT];
      if (done) begin
        rsp_y_q   <= alu_y;
        rsp_tag_q <= pipe_tag_q[ALU_LAT];
      end
    end
  end

  // In-flight count: +1 per grant, -1 per result leaving the ALU.
  always_comb begin
    inflight_d = inflight_q;
    if (flush) begin
      inflight_d = '0;
    end else if (gnt && !done) begin
      inflight_d = inflight_q + 3'd1;
    end else if (!gnt && done) begin
      inflight_d = inflight_q - 3'd1;
    end
  end

  // Sleep FSM next state: count idle cycles, sleep, then one wake cycle before granting.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    if (flush) begin
      state_d = StActive;
      idle_d  = '0;
    end else begin
      case (state_q)
        StActive: begin
          if (!rq0_valid && !rq1_valid && inflight_q == 3'd0) begin
            if (idle_q == 8'(IDLE_CYC - 1)) begin
              state_d = StSleep;
              idle_d  = '0;
            end else begin
              idle_d = idle_q + 8'd1;
            end
          end else begin
            idle_d = '0;
          end
        end
        StSleep: if (rq0_valid || rq1_valid) state_d = StWake;
        StWake:  state_d = StActive;
        default: state_d = StActive;
      endcase
    end
  end

  // State, idle counter and in-flight count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StActive;
      idle_q     <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      inflight_q <= inflight_d;
    end
  end

  assign alu_add_muln = alu_add_muln_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_tag      = rsp_tag_q;
  assign inflight     = inflight_q;
  assign alu_sleep    = (state_q == StSleep);

endmodule

// File: doc/fpalu_arb.md
Name: fpalu_arb

Overview:
- Shares one FPALU (FP29i add / FP16i multiply, fixed-latency, no stall) between two requesters: port 0 (multiply feeder) and port 1 (accumulate feeder).
- Round-robin arbitration, registered issue to the ALU, and a latency-matched tag pipeline that routes each result back to its owner.
- Idle-driven sleep control so the FIR top can gate the ALU clock.

Parameters:
- ALU_LAT, 4, cycles from an ALU input cycle to a valid alu_y (FPALU: comb s1, registers s2..s5).
- TAGW, 4, requester-owned tag width.
- IDLE_CYC, 8, consecutive empty cycles before sleep; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all in-flight ops.
- rqN_valid  in  1  N=0,1: request valid.
- rqN_ready  out  1  N=0,1: grant; transfer on valid&ready.
- rqN_add_muln  in  1  N=0,1: 1 = add, 0 = multiply.
- rqN_a  in  29  N=0,1: operand A {sgn, exp[5:0], man_dn[21:0]}.
- rqN_b  in  29  N=0,1: operand B, same packing.
- rqN_tag  in  TAGW  N=0,1: returned with the result.
- alu_add_muln  out  1  to FPALU.
- alu_a  out  29  to FPALU din_uni_a_*.
- alu_b  out  29  to FPALU din_uni_b_*.
- alu_y  in  29  from FPALU dout_uni_y_*.
- rsp0_valid  out  1  result for port 0.
- rsp1_valid  out  1  result for port 1.
- rsp_y  out  29  registered result, shared by both ports.
- rsp_tag  out  TAGW  tag of the returned op.
- inflight  out  3  ops issued and not yet returned.
- alu_sleep  out  1  1 = ALU clock may be gated.

Behaviour:
- Reset values: all outputs 0; last_grant = 1, so port 0 wins the first contention; state ACTIVE; idle counter 0.
- Arbitration (ACTIVE only, at most one grant per cycle):
  - One valid port: it is granted.
  - Both valid: the port not in last_grant is granted.
  - rqN_ready is a combinational function of the valids and state and may depend on rqN_valid.
  - A requester holds valid and operands stable until ready.
- Issue: on a grant at cycle T, alu_add_muln/alu_a/alu_b are registered and presented during T+1.
  - With no grant, these outputs hold their last value, which minimises toggling.
- Tag pipeline:
  - A shift register of depth ALU_LAT+1 carries {valid, port, tag}.
  - At T+1+ALU_LAT, alu_y is captured into rsp_y; the rspN_valid for the owning port and rsp_tag are driven during T+2+ALU_LAT (default T+6).
  - rspN_valid is a one-cycle pulse with no backpressure; the requester must accept it.
  - Back-to-back grants produce back-to-back responses in issue order.
- inflight:
  - +1 on a grant, -1 on a response, unchanged when both occur in the same cycle.
  - Maximum ALU_LAT+1; it never wraps because the grant rate is at most one per cycle.
- flush (sampled at clk):
  - Clears every tag-pipeline valid bit, so no response is emitted for already-issued ops.
  - inflight is set to 0 and the state returns to ACTIVE.
  - Grants are suppressed in the flush cycle.
  - last_grant is kept.
- Sleep FSM:
  - ACTIVE:
    - The idle counter increments when no rqN_valid and inflight==0; otherwise it clears.
    - When it reaches IDLE_CYC, go to SLEEP and set alu_sleep=1.
  - SLEEP:
    - rqN_ready=0.
    - Any rqN_valid moves to WAKE and sets alu_sleep=0 in the same transition, so it reads 0 from the next cycle.
  - WAKE: one cycle with no grant, then ACTIVE, where the grant occurs.
  - Wake-to-grant latency from a valid seen in SLEEP is 2 cycles.
  - flush during SLEEP or WAKE moves to ACTIVE and clears the idle counter.
- Reset mid-operation: in-flight ops are discarded and no response is emitted.

Test Plan:
- Single-port latency: rq0 mul, tag=3, issued at cycle 10 -> alu_add_muln=0 with operands at cycle 11; rsp0_valid=1, rsp_tag=3, rsp_y=alu_y(cycle 15) at cycle 16; rsp1_valid stays 0.
- Round-robin: both ports valid continuously for 6 cycles from reset -> grants 0,1,0,1,0,1; responses in the same order; inflight peaks at 5.
- Back-to-back: rq1 streams 8 adds -> rsp1_valid high 8 consecutive cycles, tags in order; inflight returns to 0.
- Flush: issue 3 ops, flush 2 cycles later -> no rspN_valid, inflight=0 next cycle; a new request is granted on the cycle after flush.
- Sleep/wake: IDLE_CYC=8 with no activity -> alu_sleep=1 after 8 idle cycles; rq0_valid raised -> alu_sleep=0 next cycle, rq0_ready=1 two cycles after the valid.
- Async reset: assert rst_n=0 with 4 ops in flight -> all outputs 0 immediately; after release, no stale response and port 0 wins the first contention.
